// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared types and constants for the decode-stage branch resolution unit.
//   cond_t       : 3-bit branch condition codes
//   bru_state_t  : resolution FSM states
//   FLAG_*       : bit positions inside the {Z,V,N} flags bus
//   b_offset()   : sign-extended, word-scaled PC-relative offset for B
// ---------------------------------------------------------------------------
package branch_pkg;

    typedef enum logic [2:0] {
        COND_NE  = 3'b000,
        COND_EQ  = 3'b001,
        COND_GT  = 3'b010,
        COND_LT  = 3'b011,
        COND_GTE = 3'b100,
        COND_LTE = 3'b101,
        COND_OV  = 3'b110,
        COND_UNC = 3'b111
    } cond_t;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } bru_state_t;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    localparam logic [15:0] INSTR_BYTES = 16'd2;

    // The 9-bit immediate counts instructions (2 bytes each), so it is
    // sign-extended and shifted left by one to form a 16-bit byte offset.
    function automatic logic [15:0] b_offset(input logic [8:0] imm);
        return {{6{imm[8]}}, imm, 1'b0};
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational evaluation of a branch condition code against the
// current {Z,V,N} flags.
// Ports:
//   cond      in  3  condition code (see cond_t)
//   flags     in  3  {Z,V,N}
//   cond_met  out 1  condition satisfied
// ---------------------------------------------------------------------------
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       cond_met
);

    logic z;
    logic v;
    logic n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    always_comb begin
        cond_met = 1'b0;
        case (cond_t'(cond))
            COND_NE:  cond_met = ~z;
            COND_EQ:  cond_met = z;
            COND_GT:  cond_met = ~z & ~n;
            COND_LT:  cond_met = n;
            COND_GTE: cond_met = z | (~z & ~n);
            COND_LTE: cond_met = n | z;
            COND_OV:  cond_met = v;
            COND_UNC: cond_met = 1'b1;
            default:  cond_met = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Decode-stage branch resolution. Resolves direction and target of the branch
// in IF/ID, checks it against the prediction carried with the instruction and
// drives predictor update strobes plus the PC redirect / IF/ID flush back to
// fetch. A branch seen while decode is stalled is resolved once, its result
// latched, and the redirect is issued on the cycle decode advances, so each
// branch produces exactly one predictor update and at most one redirect.
//
// Optional feature macro: BRU_PERF_CNT_EN builds saturating performance
// counters; without it the counter outputs are tied to zero.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   enable                     IF/ID advances this cycle
//   IF_ID_PC_curr              PC of the instruction in decode
//   IF_ID_prediction           2-bit predictor state (bit 1 = predicted taken)
//   IF_ID_predicted_target     predicted target
//   is_branch / is_branch_reg  decoded B / BR (BR wins if both set)
//   cond, imm, reg_target      condition code, B offset, BR target
//   flags                      {Z,V,N}
//   actual_taken/actual_target resolved direction / next PC
//   wen_BHT, wen_BTB           predictor update strobes
//   update_PC, flush_IF_ID     fetch redirect and IF/ID bubble
//   branch_count, taken_count, mispredict_count   performance counters
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no resolved branch outstanding; outputs follow IF/ID directly
// HELD  | branch resolved during a stall; result latched, redirect pending
// ---------------------------------------------------------------------------
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [15:0]      IF_ID_PC_curr,
    input  logic [1:0]       IF_ID_prediction,
    input  logic [15:0]      IF_ID_predicted_target,
    input  logic             is_branch,
    input  logic             is_branch_reg,
    input  logic [2:0]       cond,
    input  logic [8:0]       imm,
    input  logic [15:0]      reg_target,
    input  logic [2:0]       flags,
    output logic             actual_taken,
    output logic [15:0]      actual_target,
    output logic             wen_BHT,
    output logic             wen_BTB,
    output logic             update_PC,
    output logic             flush_IF_ID,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count,
    output logic [CNT_W-1:0] mispredict_count
);

    bru_state_t state;
    bru_state_t state_next;

    logic        cond_met;
    logic        br_valid;
    logic [15:0] seq_pc;
    logic [15:0] br_target;
    logic        res_taken;
    logic [15:0] res_target;
    logic        mispredicted;
    logic        miscomp;
    logic        need_redirect;
    logic        capture;

    logic        pend_taken;
    logic [15:0] pend_target;
    logic        pend_redirect;

    // Only the direction bit of the 2-bit predictor state matters here.
    logic unused_pred_lsb;
    assign unused_pred_lsb = IF_ID_prediction[0];

    branch_cond_eval u_cond_eval (
        .cond     (cond),
        .flags    (flags),
        .cond_met (cond_met)
    );

    // ---------------- resolution datapath ----------------
    assign br_valid  = is_branch | is_branch_reg;
    assign seq_pc    = IF_ID_PC_curr + INSTR_BYTES;
    assign br_target = is_branch_reg ? reg_target
                                     : seq_pc + b_offset(imm);

    assign res_taken     = br_valid & cond_met;
    assign res_target    = res_taken ? br_target : seq_pc;
    assign mispredicted  = IF_ID_prediction[1] != res_taken;
    assign miscomp       = IF_ID_predicted_target != br_target;
    assign need_redirect = br_valid & (mispredicted | (res_taken & miscomp));

    // A branch first seen while decode is stalled is frozen in the pending
    // registers so later flag changes cannot alter its outcome.
    assign capture = (state == IDLE) & ~enable & br_valid;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_taken    <= 1'b0;
            pend_target   <= 16'h0000;
            pend_redirect <= 1'b0;
        end else if (capture) begin
            pend_taken    <= res_taken;
            pend_target   <= res_target;
            pend_redirect <= need_redirect;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (capture) state_next = HELD;
            HELD:    if (enable)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Outputs are forced low while reset is asserted, independent of state.
    always_comb begin
        actual_taken  = 1'b0;
        actual_target = 16'h0000;
        wen_BHT       = 1'b0;
        wen_BTB       = 1'b0;
        update_PC     = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    actual_taken  = res_taken;
                    actual_target = res_target;
                    wen_BHT       = br_valid;
                    wen_BTB       = res_taken;
                    update_PC     = enable & need_redirect;
                end
                HELD: begin
                    actual_taken  = pend_taken;
                    actual_target = pend_target;
                    update_PC     = enable & pend_redirect;
                end
                default: begin
                    actual_taken  = 1'b0;
                end
            endcase
        end
    end

    assign flush_IF_ID = update_PC;

    // ---------------- performance counters ----------------
`ifdef BRU_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count     <= '0;
            taken_count      <= '0;
            mispredict_count <= '0;
        end else begin
            if (wen_BHT && branch_count != CNT_MAX) begin
                branch_count <= branch_count + CNT_ONE;
            end
            if (wen_BTB && taken_count != CNT_MAX) begin
                taken_count <= taken_count + CNT_ONE;
            end
            if (update_PC && mispredict_count != CNT_MAX) begin
                mispredict_count <= mispredict_count + CNT_ONE;
            end
        end
    end
`else
    assign branch_count     = '0;
    assign taken_count      = '0;
    assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic [15:0]      IF_ID_PC_curr = 16'h0;
    logic [1:0]       IF_ID_prediction = 2'b00;
    logic [15:0]      IF_ID_predicted_target = 16'h0;
    logic             is_branch = 1'b0;
    logic             is_branch_reg = 1'b0;
    logic [2:0]       cond = 3'b000;
    logic [8:0]       imm = 9'h0;
    logic [15:0]      reg_target = 16'h0;
    logic [2:0]       flags = 3'b000;
    logic             actual_taken;
    logic [15:0]      actual_target;
    logic             wen_BHT;
    logic             wen_BTB;
    logic             update_PC;
    logic             flush_IF_ID;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] taken_count;
    logic [CNT_W-1:0] mispredict_count;

    branch_resolve_unit #(.CNT_W(CNT_W)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .enable                 (enable),
        .IF_ID_PC_curr          (IF_ID_PC_curr),
        .IF_ID_prediction       (IF_ID_prediction),
        .IF_ID_predicted_target (IF_ID_predicted_target),
        .is_branch              (is_branch),
        .is_branch_reg          (is_branch_reg),
        .cond                   (cond),
        .imm                    (imm),
        .reg_target             (reg_target),
        .flags                  (flags),
        .actual_taken           (actual_taken),
        .actual_target          (actual_target),
        .wen_BHT                (wen_BHT),
        .wen_BTB                (wen_BTB),
        .update_PC              (update_PC),
        .flush_IF_ID            (flush_IF_ID),
        .branch_count           (branch_count),
        .taken_count            (taken_count),
        .mispredict_count       (mispredict_count)
    );

    always #5 clk = ~clk;

    // {taken, target[15:0], bht, btb, upd, flush, bc, tc, mc}
    typedef struct {
        string       name;
        logic [32:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_vec  = 0;
    int  n_miss = 0;

    logic [CNT_W-1:0] bc_m = '0;
    logic [CNT_W-1:0] tc_m = '0;
    logic [CNT_W-1:0] mc_m = '0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        logic [CNT_W-1:0] r;
        r = c;
`ifdef BRU_PERF_CNT_EN
        if (inc && c != {CNT_W{1'b1}}) r = c + 1'b1;
`else
        r = '0;
        if (inc) r = '0;
`endif
        return r;
    endfunction

    // Monitor: compares every pushed expectation against the DUT half a
    // cycle after the stimulus was applied.
    always @(negedge clk) begin
        sb_t         e;
        logic [32:0] act;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {actual_taken, actual_target, wen_BHT, wen_BTB, update_PC,
                   flush_IF_ID, branch_count, taken_count, mispredict_count};
            n_vec++;
            if (act !== e.exp) begin
                n_miss++;
                $display("FAIL %s: got tk=%b tgt=%h bht=%b btb=%b upd=%b fl=%b cnt=%h/%h/%h, want tk=%b tgt=%h bht=%b btb=%b upd=%b fl=%b cnt=%h/%h/%h",
                         e.name, act[32], act[31:16], act[15], act[14], act[13], act[12],
                         act[11:8], act[7:4], act[3:0],
                         e.exp[32], e.exp[31:16], e.exp[15], e.exp[14], e.exp[13], e.exp[12],
                         e.exp[11:8], e.exp[7:4], e.exp[3:0]);
            end
        end
    end

    task automatic vec(input string nm, input logic en, input logic [15:0] pc,
                       input logic [1:0] pred, input logic [15:0] ptgt,
                       input logic b, input logic br, input logic [2:0] cnd,
                       input logic [8:0] im, input logic [15:0] rt, input logic [2:0] fl,
                       input logic e_tk, input logic [15:0] e_tg,
                       input logic e_bht, input logic e_btb, input logic e_upd);
        sb_t e;
        @(posedge clk);
        #1;
        rst_n                  = 1'b1;
        enable                 = en;
        IF_ID_PC_curr          = pc;
        IF_ID_prediction       = pred;
        IF_ID_predicted_target = ptgt;
        is_branch              = b;
        is_branch_reg          = br;
        cond                   = cnd;
        imm                    = im;
        reg_target             = rt;
        flags                  = fl;
        e.name = nm;
        e.exp  = {e_tk, e_tg, e_bht, e_btb, e_upd, e_upd, bc_m, tc_m, mc_m};
        sb_q.push_back(e);
        bc_m = sat_inc(bc_m, e_bht);
        tc_m = sat_inc(tc_m, e_btb);
        mc_m = sat_inc(mc_m, e_upd);
    endtask

    // Reset asserted with a live taken branch on the inputs: outputs must be 0.
    task automatic rst_vec(input string nm);
        sb_t e;
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        enable        = 1'b1;
        is_branch     = 1'b1;
        cond          = 3'b111;
        IF_ID_PC_curr = 16'h0010;
        imm           = 9'h004;
        e.name = nm;
        e.exp  = '0;
        sb_q.push_back(e);
        bc_m = '0;
        tc_m = '0;
        mc_m = '0;
    endtask

    initial begin
        rst_vec("reset_init");
        //   name          en  pc       pred   ptgt     b  br cond    imm     rtgt     flags   tk  tgt      bht btb upd
        vec("b_unc_mis",   1, 16'h0010, 2'b00, 16'h0000, 1, 0, 3'b111, 9'h004, 16'h0000, 3'b000, 1, 16'h001A, 1, 1, 1);
        vec("b_eq_nt_mis", 1, 16'h0010, 2'b11, 16'h001A, 1, 0, 3'b001, 9'h004, 16'h0000, 3'b000, 0, 16'h0012, 1, 0, 1);
        vec("b_lt_back",   1, 16'h0010, 2'b10, 16'h000E, 1, 0, 3'b011, 9'h1FE, 16'h0000, 3'b001, 1, 16'h000E, 1, 1, 0);
        vec("non_branch",  1, 16'h0100, 2'b11, 16'h0000, 0, 0, 3'b111, 9'h004, 16'h0000, 3'b000, 0, 16'h0102, 0, 0, 0);
        vec("b_tgt_mis",   1, 16'h0020, 2'b11, 16'h0044, 1, 0, 3'b111, 9'h010, 16'h0000, 3'b000, 1, 16'h0042, 1, 1, 1);
        vec("br_ov",       1, 16'h0030, 2'b00, 16'h0000, 0, 1, 3'b110, 9'h000, 16'h1234, 3'b010, 1, 16'h1234, 1, 1, 1);
        vec("both_br_win", 1, 16'h0040, 2'b11, 16'hBEEF, 1, 1, 3'b111, 9'h004, 16'hBEEF, 3'b000, 1, 16'hBEEF, 1, 1, 0);
        vec("b_ne_z",      1, 16'h0050, 2'b01, 16'h0000, 1, 0, 3'b000, 9'h004, 16'h0000, 3'b100, 0, 16'h0052, 1, 0, 0);
        vec("b_gt",        1, 16'h0060, 2'b10, 16'h0066, 1, 0, 3'b010, 9'h002, 16'h0000, 3'b000, 1, 16'h0066, 1, 1, 0);
        vec("b_gte_n",     1, 16'h0070, 2'b00, 16'h0000, 1, 0, 3'b100, 9'h004, 16'h0000, 3'b001, 0, 16'h0072, 1, 0, 0);
        vec("b_lte_z",     1, 16'h0080, 2'b10, 16'h0082, 1, 0, 3'b101, 9'h000, 16'h0000, 3'b100, 1, 16'h0082, 1, 1, 0);
        vec("b_wrap",      1, 16'hFFFE, 2'b10, 16'h0002, 1, 0, 3'b111, 9'h001, 16'h0000, 3'b000, 1, 16'h0002, 1, 1, 0);
        // Stalled mispredicted taken branch, flags toggled while held.
        vec("stall_c1",    0, 16'h0200, 2'b00, 16'h0000, 1, 0, 3'b011, 9'h008, 16'h0000, 3'b001, 1, 16'h0212, 1, 1, 0);
        vec("stall_c2",    0, 16'h0200, 2'b00, 16'h0000, 1, 0, 3'b011, 9'h008, 16'h0000, 3'b000, 1, 16'h0212, 0, 0, 0);
        vec("stall_c3",    0, 16'h0200, 2'b00, 16'h0000, 1, 0, 3'b011, 9'h008, 16'h0000, 3'b001, 1, 16'h0212, 0, 0, 0);
        vec("stall_rel",   1, 16'h0200, 2'b00, 16'h0000, 1, 0, 3'b011, 9'h008, 16'h0000, 3'b000, 1, 16'h0212, 0, 0, 1);
        vec("post_stall",  1, 16'h0202, 2'b00, 16'h0000, 0, 0, 3'b000, 9'h000, 16'h0000, 3'b000, 0, 16'h0204, 0, 0, 0);
        // Reset while HELD with a redirect pending.
        vec("held_c1",     0, 16'h0300, 2'b00, 16'h0000, 1, 0, 3'b111, 9'h001, 16'h0000, 3'b000, 1, 16'h0304, 1, 1, 0);
        vec("held_c2",     0, 16'h0300, 2'b00, 16'h0000, 1, 0, 3'b111, 9'h001, 16'h0000, 3'b000, 1, 16'h0304, 0, 0, 0);
        rst_vec("reset_held");
        vec("post_reset",  1, 16'h0400, 2'b00, 16'h0000, 0, 0, 3'b111, 9'h001, 16'h0000, 3'b000, 0, 16'h0402, 0, 0, 0);
        // Saturation: 20 mispredicted taken branches.
        for (int i = 0; i < 20; i++) begin
            vec("sat_br",  1, 16'h0500, 2'b00, 16'h0000, 1, 0, 3'b111, 9'h000, 16'h0000, 3'b000, 1, 16'h0502, 1, 1, 1);
        end
        vec("sat_final",   1, 16'h0600, 2'b00, 16'h0000, 0, 0, 3'b000, 9'h000, 16'h0000, 3'b000, 0, 16'h0602, 0, 0, 0);

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
